pj_exibe_sequencia: RTL and testbench

//   MindFocus sequence presenter: the output side of the player interface. It reads the

---
 rtl/pj_exibe_sequencia_if.sv | 25 ++
 rtl/pj_exibe_sequencia.sv | 121 ++++++++++++
 tb/tb_pj_exibe_sequencia.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pj_exibe_sequencia_if.sv
// Player-output bundle for the MindFocus sequence presenter: game-FSM control,
// ROM read port, LED drive and debug taps.
interface pj_exibe_sequencia_if;
    logic       iniciar;
    logic       abortar;
    logic [3:0] base_endereco;
    logic [3:0] comprimento;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [2:0] db_estado;
    logic [3:0] db_indice;

    modport slave (
        input  iniciar, abortar, base_endereco, comprimento, mem_dado,
        output mem_endereco, leds, ocupado, fim, db_estado, db_indice
    );

    modport master (
        output iniciar, abortar, base_endereco, comprimento, mem_dado,
        input  mem_endereco, leds, ocupado, fim, db_estado, db_indice
    );
endinterface

// File: rtl/pj_exibe_sequencia.sv
// MindFocus sequence presenter: fetches each item of the round's pattern from the
// synchronous game ROM and shows it on the LEDs with fixed on/off timing.
module pj_exibe_sequencia #(
    parameter int T_ON  = 25000000,
    parameter int T_OFF = 12500000,
    parameter int CNT_W = 26
) (
    input  logic                  clock,
    input  logic                  reset,
    pj_exibe_sequencia_if.slave   bus
);
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        LE      = 3'd2,
        ACESO   = 3'd3,
        APAGADO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(T_OFF - 1);

    estado_t          estado, estado_prox;
    logic [CNT_W-1:0] timer, timer_prox;
    logic [3:0]       indice, indice_prox;
    logic [3:0]       endereco, endereco_prox;
    logic [3:0]       leds_q, leds_prox;
    logic [3:0]       comp_q, comp_prox;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            timer    <= '0;
            indice   <= '0;
            endereco <= '0;
            leds_q   <= '0;
            comp_q   <= '0;
        end else begin
            estado   <= estado_prox;
            timer    <= timer_prox;
            indice   <= indice_prox;
            endereco <= endereco_prox;
            leds_q   <= leds_prox;
            comp_q   <= comp_prox;
        end
    end

    // NOTE: every signal gets a hold default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        estado_prox   = estado;
        timer_prox    = timer;
        indice_prox   = indice;
        endereco_prox = endereco;
        leds_prox     = leds_q;
        comp_prox     = comp_q;

        unique case (estado)
            OCIOSO: begin
                if (bus.iniciar && !bus.abortar) begin
                    comp_prox   = bus.comprimento;
                    indice_prox = '0;
                    if (bus.comprimento == 4'd0) begin
                        estado_prox = FIM;
                    end else begin
                        endereco_prox = bus.base_endereco;
                        estado_prox   = BUSCA;
                    end
                end
            end
            BUSCA: estado_prox = LE;
            LE: begin
                leds_prox   = bus.mem_dado;
                timer_prox  = '0;
                estado_prox = ACESO;
            end
            ACESO: begin
                if (timer == ON_LAST) begin
                    leds_prox   = '0;
                    timer_prox  = '0;
                    estado_prox = APAGADO;
                end else begin
                    timer_prox = timer + CNT_W'(1);
                end
            end
            APAGADO: begin
                if (timer == OFF_LAST) begin
                    timer_prox = '0;
                    if (indice == comp_q - 4'd1) begin
                        estado_prox = FIM;
                    end else begin
                        indice_prox   = indice + 4'd1;
                        endereco_prox = endereco + 4'd1;
                        estado_prox   = BUSCA;
                    end
                end else begin
                    timer_prox = timer + CNT_W'(1);
                end
            end
            FIM:     estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase

        // Abort overrides every transition, including FIM, so no fim pulse follows it.
        if (bus.abortar && estado != OCIOSO) begin
            estado_prox = OCIOSO;
            leds_prox   = '0;
            timer_prox  = '0;
        end
    end

    assign bus.mem_endereco = endereco;
    assign bus.leds         = leds_q;
    assign bus.ocupado      = (estado != OCIOSO);
    assign bus.fim          = (estado == FIM);
    assign bus.db_estado    = estado;
    assign bus.db_indice    = indice;
endmodule

// File: tb/tb_pj_exibe_sequencia.sv
// Bench for pj_exibe_sequencia: a cycle model pushes expected per-cycle outputs into a
// scoreboard queue at each start, and the drain loop compares them on falling edges.
module tb_pj_exibe_sequencia;
    localparam int T_ON  = 4;
    localparam int T_OFF = 2;

    typedef struct packed {
        logic [3:0] leds;
        logic       fim;
        logic       ocupado;
        logic [3:0] addr;
        logic [3:0] idx;
        logic [2:0] est;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [3:0] m_addr = 4'd0;
    logic [3:0] m_idx  = 4'd0;

    pj_exibe_sequencia_if bus ();

    pj_exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural 16x4 ROM with one cycle of read latency.
    always_ff @(posedge clock) bus.mem_dado <= bus.mem_endereco ^ 4'hA;

    function automatic exp_t observed();
        return {bus.leds, bus.fim, bus.ocupado, bus.mem_endereco, bus.db_indice, bus.db_estado};
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back({4'd0, 1'b0, 1'b0, m_addr, m_idx, 3'd0});
    endtask

    // Expected trace of a whole sequence, one entry per cycle after the start edge.
    task automatic push_seq(input logic [3:0] base, input logic [3:0] len);
        logic [3:0] a;
        if (len == 4'd0) m_idx = 4'd0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 4'(i);
            for (int k = 0; k < 2 + T_ON + T_OFF; k++) begin
                exp_t e;
                e.leds    = (k >= 2 && k < 2 + T_ON) ? (a ^ 4'hA) : 4'd0;
                e.fim     = 1'b0;
                e.ocupado = 1'b1;
                e.addr    = a;
                e.idx     = 4'(i);
                e.est     = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : (k < 2 + T_ON) ? 3'd3 : 3'd4;
                sb.push_back(e);
            end
            m_addr = a;
            m_idx  = 4'(i);
        end
        sb.push_back({4'd0, 1'b1, 1'b1, m_addr, m_idx, 3'd5});
        push_idle(2);
    endtask

    task automatic start(input logic [3:0] base, input logic [3:0] len);
        @(negedge clock);
        bus.base_endereco = base;
        bus.comprimento   = len;
        bus.iniciar       = 1'b1;
        bus.abortar       = 1'b0;
        push_seq(base, len);
    endtask

    // Pops one expectation per cycle; optional stray start pulse, abort or async reset.
    task automatic drain(input string name, input int pulse_at, input int abort_at,
                         input int reset_at);
        exp_t e, got;
        int c = 0;
        while (sb.size() > 0) begin
            @(negedge clock);
            c++;
            e   = sb.pop_front();
            got = observed();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got leds=%h fim=%b ocupado=%b end=%h ind=%h est=%0d, expected leds=%h fim=%b ocupado=%b end=%h ind=%h est=%0d",
                         name, c, got.leds, got.fim, got.ocupado, got.addr, got.idx, got.est,
                         e.leds, e.fim, e.ocupado, e.addr, e.idx, e.est);
            end
            bus.iniciar = (c == pulse_at);
            bus.abortar = (c == abort_at);
            if (c == pulse_at) begin
                bus.base_endereco = 4'd9;
                bus.comprimento   = 4'd7;
            end else begin
                bus.base_endereco = 4'($urandom_range(15));
                bus.comprimento   = 4'($urandom_range(15));
            end
            if (c == abort_at) begin
                sb.delete();
                m_addr = e.addr;
                m_idx  = e.idx;
                push_idle(3);
            end
            if (c == reset_at) begin
                #2 reset = 1'b0;
                #1;
                got = observed();
                n_checks++;
                if (got !== '0) begin
                    n_fail++;
                    $display("FAIL %s async reset: got %h expected all zero", name, got);
                end
                sb.delete();
                m_addr = 4'd0;
                m_idx  = 4'd0;
            end
        end
    endtask

    task automatic test_reset();
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
        bus.base_endereco = 4'd0;
        bus.comprimento   = 4'd0;
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected all zero", observed());
        end
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        push_idle(3);
        drain("reset_idle", 0, 0, 0);
    endtask

    task automatic test_basic();
        start(4'd0, 4'd3);
        drain("basic_len3", 0, 0, 0);
    endtask

    task automatic test_wrap();
        start(4'd14, 4'd3);
        drain("wrap_14", 0, 0, 0);
    endtask

    task automatic test_empty();
        start(4'd7, 4'd0);
        drain("len_zero", 0, 0, 0);
    endtask

    task automatic test_single();
        start(4'd10, 4'd1);
        drain("dark_item", 0, 0, 0);
    endtask

    task automatic test_abort();
        start(4'd0, 4'd3);
        drain("abort_aceso", 0, 12, 0);
        @(negedge clock);
        bus.iniciar = 1'b1;
        bus.abortar = 1'b1;
        push_idle(3);
        drain("abort_beats_start", 0, 0, 0);
        start(4'd0, 4'd3);
        drain("restart_after_abort", 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        start(4'd0, 4'd3);
        drain("start_while_busy", 4, 0, 0);
        start(4'd5, 4'd2);
        drain("back_to_back", 0, 0, 0);
    endtask

    task automatic test_async_reset();
        start(4'd0, 4'd3);
        drain("reset_in_apagado", 0, 0, 7);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        push_idle(4);
        drain("idle_after_reset", 0, 0, 0);
        start(4'd0, 4'd3);
        drain("run_after_reset", 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        test_single();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
